// File: rtl/bram_dual_tp.sv
// bram_dual_tp: true dual-port RAM of complex words {re, im}, each half WIDTH bits wide.
// Each half is its own block-RAM array so the real and imaginary parts can be written
// independently. A small clear engine can zero-fill the whole memory, one word per cycle.
module bram_dual_tp #(
  parameter int WIDTH      = 32,
  parameter int AW         = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               En,
  input  logic               Clr,
  output logic               Busy,
  input  logic [1:0]         We_A,
  input  logic [AW-1:0]      Addr_A,
  input  logic [2*WIDTH-1:0] DI_A,
  output logic [2*WIDTH-1:0] DO_A,
  output logic               Vld_A,
  input  logic [1:0]         We_B,
  input  logic [AW-1:0]      Addr_B,
  input  logic [2*WIDTH-1:0] DI_B,
  output logic [2*WIDTH-1:0] DO_B,
  output logic               Vld_B,
  output logic               Coll
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t            state_reg, state_next;
  logic [AW-1:0]     clr_cnt_reg;
  logic              acc;
  logic              clr_wr;
  logic              same_addr;
  logic              any_we;
  logic [1:0]        we_b_eff;
  logic [2*WIDTH-1:0] do1_a, do1_b;
  logic              vld1_a_reg, vld1_b_reg;
  logic              coll_reg;

  assign Busy      = (state_reg == CLEAR);
  assign acc       = Rst_n && En && (state_reg == IDLE);
  assign clr_wr    = Rst_n && (state_reg == CLEAR);
  assign same_addr = (Addr_A == Addr_B);
  assign any_we    = (|We_A) || (|We_B);
  // On a shared address, any half that A also writes is taken from A only.
  assign we_b_eff  = We_B & ~({2{same_addr}} & We_A);

  // State register; reset either starts a zero-fill or drops straight to IDLE.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: a Clr pulse starts a fill, the fill ends after the last address.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Clr) state_next = CLEAR;
      CLEAR:   if (clr_cnt_reg == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear address counter; wraps back to 0 naturally after the last address.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + 1'b1;
    end else begin
      clr_cnt_reg <= '0;
    end
  end

  genvar gi;
  generate
    // gi = 1 is the real (upper) half, gi = 0 the imaginary (lower) half.
    for (gi = 0; gi < 2; gi++) begin : g_half
      logic [WIDTH-1:0] mem [2**AW];
      logic [WIDTH-1:0] din_a, din_b;
      logic [WIDTH-1:0] do1_a_reg, do1_b_reg;
      logic             wr_a, wr_b;

      assign din_a = DI_A[gi*WIDTH +: WIDTH];
      assign din_b = DI_B[gi*WIDTH +: WIDTH];
      assign wr_a  = acc && We_A[gi];
      assign wr_b  = acc && we_b_eff[gi];

      // Write ports: the clear engine owns the array while it runs.
      always_ff @(posedge Clk) begin
        if (clr_wr) begin
          mem[clr_cnt_reg] <= '0;
        end else begin
          if (wr_a) mem[Addr_A] <= din_a;
          if (wr_b) mem[Addr_B] <= din_b;
        end
      end

      // Registered reads; write-first mode forwards the final merged half.
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          do1_a_reg <= '0;
          do1_b_reg <= '0;
        end else if (acc) begin
          if (RD_MODE == 0) begin
            do1_a_reg <= mem[Addr_A];
            do1_b_reg <= mem[Addr_B];
          end else begin
            if (We_A[gi])                       do1_a_reg <= din_a;
            else if (same_addr && we_b_eff[gi]) do1_a_reg <= din_b;
            else                                do1_a_reg <= mem[Addr_A];
            if (we_b_eff[gi])                   do1_b_reg <= din_b;
            else if (same_addr && We_A[gi])     do1_b_reg <= din_a;
            else                                do1_b_reg <= mem[Addr_B];
          end
        end
      end

      assign do1_a[gi*WIDTH +: WIDTH] = do1_a_reg;
      assign do1_b[gi*WIDTH +: WIDTH] = do1_b_reg;
    end
  endgenerate

  // Stage-1 valid flags and the collision flag, aligned with stage-1 data.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      vld1_a_reg <= 1'b0;
      vld1_b_reg <= 1'b0;
      coll_reg   <= 1'b0;
    end else begin
      vld1_a_reg <= acc;
      vld1_b_reg <= acc;
      coll_reg   <= acc && same_addr && any_we;
    end
  end

  assign Coll = coll_reg;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [2*WIDTH-1:0] do2_a_reg, do2_b_reg;
      logic               vld2_a_reg, vld2_b_reg;

      // Optional second stage: data only advances when stage 1 holds a valid word.
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          do2_a_reg  <= '0;
          do2_b_reg  <= '0;
          vld2_a_reg <= 1'b0;
          vld2_b_reg <= 1'b0;
        end else begin
          vld2_a_reg <= vld1_a_reg;
          vld2_b_reg <= vld1_b_reg;
          if (vld1_a_reg) do2_a_reg <= do1_a;
          if (vld1_b_reg) do2_b_reg <= do1_b;
        end
      end

      assign DO_A  = do2_a_reg;
      assign DO_B  = do2_b_reg;
      assign Vld_A = vld2_a_reg;
      assign Vld_B = vld2_b_reg;
    end else begin : g_no_out_reg
      assign DO_A  = do1_a;
      assign DO_B  = do1_b;
      assign Vld_A = vld1_a_reg;
      assign Vld_B = vld1_b_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dual_tp.sv
// Directed bench for bram_dual_tp: one read-first/latency-1 instance and one
// write-first/latency-2 instance share the same stimulus.
module tb_bram_dual_tp;

  logic        Clk = 1'b0;
  logic        Rst_n, En, Clr;
  logic [1:0]  We_A, We_B;
  logic [7:0]  Addr_A, Addr_B;
  logic [63:0] DI_A, DI_B;

  logic [63:0] do_a0, do_b0, do_a1, do_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1;
  logic        coll0, coll1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  int n0, n1, vbad;

  always #5 Clk = ~Clk;

  bram_dual_tp #(.WIDTH(32), .AW(8), .RD_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Clr(Clr), .Busy(busy0),
    .We_A(We_A), .Addr_A(Addr_A), .DI_A(DI_A), .DO_A(do_a0), .Vld_A(vld_a0),
    .We_B(We_B), .Addr_B(Addr_B), .DI_B(DI_B), .DO_B(do_b0), .Vld_B(vld_b0),
    .Coll(coll0)
  );

  bram_dual_tp #(.WIDTH(32), .AW(8), .RD_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Clr(Clr), .Busy(busy1),
    .We_A(We_A), .Addr_A(Addr_A), .DI_A(DI_A), .DO_A(do_a1), .Vld_A(vld_a1),
    .We_B(We_B), .Addr_B(Addr_B), .DI_B(DI_B), .DO_B(do_b1), .Vld_B(vld_b1),
    .Coll(coll1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    En = 1'b0; We_A = 2'b00; We_B = 2'b00;
  endtask

  task automatic access(input logic [1:0] wa, input logic [7:0] aa, input logic [63:0] da,
                        input logic [1:0] wb, input logic [7:0] ab, input logic [63:0] db);
    En = 1'b1;
    We_A = wa; Addr_A = aa; DI_A = da;
    We_B = wb; Addr_B = ab; DI_B = db;
    tick();
    $display("access A we=%b addr=%h di=%h | B we=%b addr=%h di=%h", wa, aa, da, wb, ab, db);
  endtask

  task automatic flush();
    idle();
    tick();
  endtask

  // Runs a clear to completion while trying to write; counts Busy cycles per instance.
  task automatic run_clear(output int c0, output int c1, output int bad);
    c0 = 0; c1 = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (vld_a0 || vld_b0 || vld_a1 || vld_b1) bad++;
      if (busy0) begin
        En = 1'b1;
        We_A = 2'b11; Addr_A = 8'h00; DI_A = 64'hFFFF_FFFF_FFFF_FFFF;
        We_B = 2'b11; Addr_B = 8'h01; DI_B = 64'h0123_4567_89AB_CDEF;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    $display("clear run busy0=%0d busy1=%0d vld_during_busy=%0d", c0, c1, bad);
  endtask

  initial begin
    Rst_n = 1'b0; Clr = 1'b0; idle();
    Addr_A = 8'h00; Addr_B = 8'h00; DI_A = '0; DI_B = '0;
    repeat (3) tick();
    chk("rst_busy0", busy0, 1'b1);
    chk("rst_busy1", busy1, 1'b1);
    chk("rst_do_a0", do_a0, 64'h0);
    chk("rst_vld_a0", vld_a0, 1'b0);
    chk("rst_coll0", coll0, 1'b0);
    chk("rst_do_b1", do_b1, 64'h0);
    chk("rst_vld_b1", vld_b1, 1'b0);

    Rst_n = 1'b1;
    run_clear(n0, n1, vbad);
    chk("init_busy_cycles0", n0, 256);
    chk("init_busy_cycles1", n1, 256);
    chk("init_vld_during_busy", vbad, 0);

    // Cleared words read back 0; writes attempted during the clear were dropped.
    access(2'b00, 8'h00, 64'h0, 2'b00, 8'h01, 64'h0);
    chk("clr_rd_a0", do_a0, 64'h0);
    chk("clr_vld_a0", vld_a0, 1'b1);
    chk("clr_rd_b0", do_b0, 64'h0);
    chk("clr_coll0", coll0, 1'b0);
    chk("lat2_vld_a1_early", vld_a1, 1'b0);
    flush();
    chk("clr_rd_a1", do_a1, 64'h0);
    chk("clr_vld_a1", vld_a1, 1'b1);
    chk("idle_vld_a0", vld_a0, 1'b0);

    // Full write on A: read-first returns the old word, write-first the new one.
    access(2'b11, 8'h05, 64'h1111_2222_3333_4444, 2'b00, 8'h06, 64'h0);
    chk("wr05_do_a0", do_a0, 64'h0);
    chk("wr05_coll0", coll0, 1'b0);
    flush();
    chk("wr05_do_a1", do_a1, 64'h1111_2222_3333_4444);
    chk("wr05_vld_a1", vld_a1, 1'b1);
    chk("wr05_hold_a0", do_a0, 64'h0);

    // Simultaneous reads of one address: no collision, both see the word.
    access(2'b00, 8'h05, 64'h0, 2'b00, 8'h05, 64'h0);
    chk("rd05_do_a0", do_a0, 64'h1111_2222_3333_4444);
    chk("rd05_do_b0", do_b0, 64'h1111_2222_3333_4444);
    chk("rd05_coll0", coll0, 1'b0);
    chk("rd05_coll1", coll1, 1'b0);
    flush();
    chk("rd05_do_b1", do_b1, 64'h1111_2222_3333_4444);

    // A writes only the re half while B reads the same address.
    access(2'b10, 8'h05, 64'hAAAA_0000_FFFF_FFFF, 2'b00, 8'h05, 64'h0);
    chk("re05_coll0", coll0, 1'b1);
    chk("re05_coll1", coll1, 1'b1);
    chk("re05_do_b0", do_b0, 64'h1111_2222_3333_4444);
    chk("re05_do_a0", do_a0, 64'h1111_2222_3333_4444);
    flush();
    chk("re05_do_b1", do_b1, 64'hAAAA_0000_3333_4444);
    chk("re05_do_a1", do_a1, 64'hAAAA_0000_3333_4444);
    chk("re05_coll0_drop", coll0, 1'b0);
    access(2'b00, 8'h00, 64'h0, 2'b00, 8'h05, 64'h0);
    chk("re05_rd_b0", do_b0, 64'hAAAA_0000_3333_4444);

    // Both ports fully write 0x07: A wins.
    access(2'b11, 8'h07, 64'h1111_1111_1111_1111, 2'b11, 8'h07, 64'h2222_2222_2222_2222);
    chk("c07_coll0", coll0, 1'b1);
    chk("c07_do_a0", do_a0, 64'h0);
    chk("c07_do_b0", do_b0, 64'h0);
    flush();
    chk("c07_do_a1", do_a1, 64'h1111_1111_1111_1111);
    chk("c07_do_b1", do_b1, 64'h1111_1111_1111_1111);
    access(2'b00, 8'h07, 64'h0, 2'b00, 8'h07, 64'h0);
    chk("c07_rd_b0", do_b0, 64'h1111_1111_1111_1111);
    chk("c07_rd_coll0", coll0, 1'b0);

    // Split halves: re from A, im from B.
    access(2'b10, 8'h07, 64'h3333_3333_4444_4444, 2'b01, 8'h07, 64'h5555_5555_6666_6666);
    chk("s07_coll0", coll0, 1'b1);
    chk("s07_do_a0", do_a0, 64'h1111_1111_1111_1111);
    chk("s07_do_b0", do_b0, 64'h1111_1111_1111_1111);
    flush();
    chk("s07_do_a1", do_a1, 64'h3333_3333_6666_6666);
    chk("s07_do_b1", do_b1, 64'h3333_3333_6666_6666);
    access(2'b00, 8'h07, 64'h0, 2'b00, 8'h08, 64'h0);
    chk("s07_rd_a0", do_a0, 64'h3333_3333_6666_6666);

    // Writes to different addresses never interact.
    access(2'b11, 8'h0A, 64'h0A0A_0A0A_0A0A_0A0A, 2'b11, 8'h0B, 64'h0B0B_0B0B_0B0B_0B0B);
    chk("d_coll0", coll0, 1'b0);
    chk("d_coll1", coll1, 1'b0);
    chk("d_do_a0", do_a0, 64'h0);
    flush();
    chk("d_do_a1", do_a1, 64'h0A0A_0A0A_0A0A_0A0A);
    chk("d_do_b1", do_b1, 64'h0B0B_0B0B_0B0B_0B0B);
    access(2'b00, 8'h0B, 64'h0, 2'b00, 8'h0A, 64'h0);
    chk("d_rd_a0", do_a0, 64'h0B0B_0B0B_0B0B_0B0B);
    chk("d_rd_b0", do_b0, 64'h0A0A_0A0A_0A0A_0A0A);

    // Same-port read+write on 0x09.
    access(2'b11, 8'h09, 64'h5, 2'b00, 8'h0C, 64'h0);
    chk("rw09_do_a0", do_a0, 64'h0);
    flush();
    chk("rw09_do_a1", do_a1, 64'h5);

    // Clr pulse: the same-cycle access is still accepted.
    En = 1'b1; Clr = 1'b1;
    We_A = 2'b11; Addr_A = 8'h20; DI_A = 64'hDEAD_BEEF_DEAD_BEEF;
    We_B = 2'b00; Addr_B = 8'h05;
    tick();
    Clr = 1'b0;
    $display("clear pulse with write A addr=20");
    chk("clr_busy0", busy0, 1'b1);
    chk("clr_acc_vld_a0", vld_a0, 1'b1);
    chk("clr_acc_do_b0", do_b0, 64'hAAAA_0000_3333_4444);
    // Let the clear reach address 100, then reset in the middle of it.
    We_A = 2'b11; Addr_A = 8'h10; DI_A = 64'h1234;
    repeat (100) tick();
    chk("mid_busy0", busy0, 1'b1);
    chk("mid_vld_a0", vld_a0, 1'b0);
    idle();
    Rst_n = 1'b0;
    tick();
    chk("mid_rst_busy1", busy1, 1'b1);
    Rst_n = 1'b1;
    run_clear(n0, n1, vbad);
    chk("restart_busy_cycles0", n0, 256);
    chk("restart_busy_cycles1", n1, 256);
    chk("restart_vld_during_busy", vbad, 0);

    access(2'b00, 8'h00, 64'h0, 2'b00, 8'h01, 64'h0);
    chk("drop_rd_a0", do_a0, 64'h0);
    chk("drop_rd_b0", do_b0, 64'h0);
    access(2'b00, 8'h05, 64'h0, 2'b00, 8'h20, 64'h0);
    chk("zero05_a0", do_a0, 64'h0);
    chk("zero20_b0", do_b0, 64'h0);
    flush();
    chk("zero05_a1", do_a1, 64'h0);
    chk("zero20_b1", do_b1, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
